// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, E->M pipeline register and an iterative HI/LO multiply/divide unit.
// Latency: one cycle for ALU results; mult/multu take 5 busy cycles and div/divu 10. There is no stall input: md_busy only reports occupancy.
module exe_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  E_a1,
  input  logic [4:0]  E_a2,
  input  logic [4:0]  E_a3,
  input  logic [31:0] E_v1,
  input  logic [31:0] E_v2,
  input  logic        E_grf_en,
  input  logic        E_dm_en,
  input  logic [31:0] E_e32,
  input  logic [31:0] E_pc,
  input  logic [27:0] E_instrbus,
  input  logic [3:0]  md_op,
  input  logic        W_grf_en,
  input  logic [4:0]  W_a3,
  input  logic [31:0] W_vin,
  output logic [4:0]  M_a3,
  output logic        M_grf_en,
  output logic        M_dm_en,
  output logic [31:0] M_alu,
  output logic [31:0] M_v2,
  output logic [31:0] M_pc,
  output logic [27:0] M_instrbus,
  output logic [31:0] M_vin,
  output logic        md_busy
);

  localparam int B_CAL_L = 25;
  localparam int B_CAL_S = 24;
  localparam int B_ADDU  = 21;
  localparam int B_SUBU  = 20;
  localparam int B_ORI   = 19;
  localparam int B_LUI   = 15;
  localparam int B_JAL   = 13;
  localparam int B_ADD   = 9;
  localparam int B_SUB   = 8;
  localparam int B_AND   = 7;
  localparam int B_OR    = 6;
  localparam int B_XOR   = 5;
  localparam int B_NOR   = 4;
  localparam int B_ADDI  = 3;
  localparam int B_ADDIU = 2;
  localparam int B_ANDI  = 1;
  localparam int B_XORI  = 0;

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  logic [4:0]  m_a3_q;
  logic        m_grf_en_q;
  logic        m_dm_en_q;
  logic [31:0] m_alu_q;
  logic [31:0] m_v2_q;
  logic [31:0] m_pc_q;
  logic [27:0] m_instrbus_q;
  logic [31:0] m_alu_d;

  md_state_t   state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] md_a_q;
  logic [31:0] md_b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] opa;
  logic [31:0] rt_fwd;
  logic [31:0] opb;
  logic        use_imm;

  // M stage wins over W stage; register 0 never forwards.
  always_comb begin
    opa = E_v1;
    if (m_grf_en_q && (m_a3_q == E_a1) && (m_a3_q != 5'd0))
      opa = m_alu_q;
    else if (W_grf_en && (W_a3 == E_a1) && (W_a3 != 5'd0))
      opa = W_vin;
  end

  always_comb begin
    rt_fwd = E_v2;
    if (m_grf_en_q && (m_a3_q == E_a2) && (m_a3_q != 5'd0))
      rt_fwd = m_alu_q;
    else if (W_grf_en && (W_a3 == E_a2) && (W_a3 != 5'd0))
      rt_fwd = W_vin;
  end

  assign use_imm = E_instrbus[B_CAL_L] | E_instrbus[B_CAL_S] | E_instrbus[B_ORI]  |
                   E_instrbus[B_LUI]   | E_instrbus[B_ADDI]  | E_instrbus[B_ADDIU] |
                   E_instrbus[B_ANDI]  | E_instrbus[B_XORI];
  assign opb = use_imm ? E_e32 : rt_fwd;

  always_comb begin
    m_alu_d = 32'd0;
    if (md_op == MD_MFHI)
      m_alu_d = hi_q;
    else if (md_op == MD_MFLO)
      m_alu_d = lo_q;
    else if (E_instrbus[B_ADD] | E_instrbus[B_ADDU] | E_instrbus[B_ADDI] |
             E_instrbus[B_ADDIU] | E_instrbus[B_CAL_L] | E_instrbus[B_CAL_S])
      m_alu_d = opa + opb;
    else if (E_instrbus[B_SUB] | E_instrbus[B_SUBU])
      m_alu_d = opa - opb;
    else if (E_instrbus[B_AND] | E_instrbus[B_ANDI])
      m_alu_d = opa & opb;
    else if (E_instrbus[B_OR] | E_instrbus[B_ORI])
      m_alu_d = opa | opb;
    else if (E_instrbus[B_XOR] | E_instrbus[B_XORI])
      m_alu_d = opa ^ opb;
    else if (E_instrbus[B_NOR])
      m_alu_d = ~(opa | opb);
    else if (E_instrbus[B_LUI])
      m_alu_d = opb;
    else if (E_instrbus[B_JAL])
      m_alu_d = E_pc + 32'd8;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_a3_q       <= 5'd0;
      m_grf_en_q   <= 1'b0;
      m_dm_en_q    <= 1'b0;
      m_alu_q      <= 32'd0;
      m_v2_q       <= 32'd0;
      m_pc_q       <= 32'h0000_3000;
      m_instrbus_q <= 28'd0;
    end else begin
      m_a3_q       <= E_a3;
      m_grf_en_q   <= E_grf_en;
      m_dm_en_q    <= E_dm_en;
      m_alu_q      <= m_alu_d;
      m_v2_q       <= rt_fwd;
      m_pc_q       <= E_pc;
      m_instrbus_q <= E_instrbus;
    end
  end

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;

  assign prod_s = {{32{md_a_q[31]}}, md_a_q} * {{32{md_b_q[31]}}, md_b_q};
  assign prod_u = {32'd0, md_a_q} * {32'd0, md_b_q};
  assign quot_s = $signed(md_a_q) / $signed(md_b_q);
  assign rem_s  = $signed(md_a_q) % $signed(md_b_q);
  assign quot_u = md_a_q / md_b_q;
  assign rem_u  = md_a_q % md_b_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      md_a_q  <= 32'd0;
      md_b_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              md_a_q  <= opa;
              md_b_q  <= rt_fwd;
              op_q    <= md_op;
              cnt_q   <= 4'd5;
              state_q <= BUSY;
            end
            MD_DIV, MD_DIVU: begin
              md_a_q  <= opa;
              md_b_q  <= rt_fwd;
              op_q    <= md_op;
              cnt_q   <= 4'd10;
              state_q <= BUSY;
            end
            MD_MTHI: hi_q <= opa;
            MD_MTLO: lo_q <= opa;
            default: ;
          endcase
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            case (op_q)
              MD_MULT:  {hi_q, lo_q} <= prod_s;
              MD_MULTU: {hi_q, lo_q} <= prod_u;
              MD_DIV: begin
                if (md_b_q != 32'd0) begin
                  lo_q <= quot_s;
                  hi_q <= rem_s;
                end
              end
              MD_DIVU: begin
                if (md_b_q != 32'd0) begin
                  lo_q <= quot_u;
                  hi_q <= rem_u;
                end
              end
              default: ;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_a3       = m_a3_q;
  assign M_grf_en   = m_grf_en_q;
  assign M_dm_en    = m_dm_en_q;
  assign M_alu      = m_alu_q;
  assign M_v2       = m_v2_q;
  assign M_pc       = m_pc_q;
  assign M_instrbus = m_instrbus_q;
  assign M_vin      = m_alu_q;
  assign md_busy    = (state_q == BUSY);

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboarded bench for exe_stage: expected M_alu values are queued at issue and checked one cycle later.
module tb_exe_stage;
  logic        clk;
  logic        reset;
  logic [4:0]  E_a1, E_a2, E_a3;
  logic [31:0] E_v1, E_v2;
  logic        E_grf_en, E_dm_en;
  logic [31:0] E_e32, E_pc;
  logic [27:0] E_instrbus;
  logic [3:0]  md_op;
  logic        W_grf_en;
  logic [4:0]  W_a3;
  logic [31:0] W_vin;
  logic [4:0]  M_a3;
  logic        M_grf_en, M_dm_en;
  logic [31:0] M_alu, M_v2, M_pc, M_vin;
  logic [27:0] M_instrbus;
  logic        md_busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  int cycles;

  exe_stage dut (
    .clk(clk), .reset(reset),
    .E_a1(E_a1), .E_a2(E_a2), .E_a3(E_a3),
    .E_v1(E_v1), .E_v2(E_v2),
    .E_grf_en(E_grf_en), .E_dm_en(E_dm_en),
    .E_e32(E_e32), .E_pc(E_pc), .E_instrbus(E_instrbus),
    .md_op(md_op),
    .W_grf_en(W_grf_en), .W_a3(W_a3), .W_vin(W_vin),
    .M_a3(M_a3), .M_grf_en(M_grf_en), .M_dm_en(M_dm_en),
    .M_alu(M_alu), .M_v2(M_v2), .M_pc(M_pc), .M_instrbus(M_instrbus),
    .M_vin(M_vin), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int ADDU = 21, SUBU = 20, ORI = 19, LUI = 15, JAL = 13, ADD = 9, SUB = 8;
  localparam int AND_ = 7, OR_ = 6, XOR_ = 5, NOR_ = 4;

  function automatic logic [27:0] bit_of(input int b);
    logic [27:0] v;
    v = 28'd0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] r_model(input int b, input logic [31:0] a, input logic [31:0] bb);
    case (b)
      ADDU, ADD: return a + bb;
      SUBU, SUB: return a - bb;
      AND_:      return a & bb;
      OR_:       return a | bb;
      XOR_:      return a ^ bb;
      NOR_:      return ~(a | bb);
      default:   return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [27:0] bus, input logic [3:0] md, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] e32, input logic [31:0] pc);
    E_instrbus = bus; md_op = md; E_v1 = v1; E_v2 = v2; E_e32 = e32; E_pc = pc;
    E_a1 = 5'd0; E_a2 = 5'd0; E_a3 = 5'd0; E_grf_en = 1'b0; E_dm_en = 1'b0;
    W_grf_en = 1'b0; W_a3 = 5'd0; W_vin = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (md_busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(bit_of(ADDU), 4'd0, 32'h11, 32'h22, 32'h0, 32'h4444);
    E_a3 = 5'd9; E_grf_en = 1'b1; E_dm_en = 1'b1;
    step(); step();
    checks++; if (M_pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", M_pc, 32'h3000); end
    checks++; if (M_alu !== 32'h0) begin errors++; $display("FAIL reset_alu: got %h want 0", M_alu); end
    checks++; if ({M_a3, M_grf_en, M_dm_en} !== 7'd0) begin errors++; $display("FAIL reset_ctl: got %h want 0", {M_a3, M_grf_en, M_dm_en}); end
    checks++; if ({M_instrbus, M_v2} !== 60'd0) begin errors++; $display("FAIL reset_bus_v2: got %h want 0", {M_instrbus, M_v2}); end
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", md_busy); end
    #3 reset = 1'b1;
    exp_q.push_back(32'h33);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e || M_pc !== 32'h4444 || M_a3 !== 5'd9 || M_dm_en !== 1'b1)
      begin errors++; $display("FAIL first_edge: got alu=%h pc=%h a3=%0d dm=%b want alu=%h pc=4444 a3=9 dm=1", M_alu, M_pc, M_a3, M_dm_en, e); end
  endtask

  task automatic test_forwarding();
    drive(bit_of(ORI), 4'd0, 32'h0, 32'h0, 32'h5, 32'h3000);
    E_a3 = 5'd1; E_grf_en = 1'b1;
    step();
    drive(bit_of(ADDU), 4'd0, 32'h0, 32'h0, 32'h0, 32'h3004);
    E_a1 = 5'd1; E_a2 = 5'd2; E_a3 = 5'd3; E_grf_en = 1'b1;
    W_grf_en = 1'b1; W_a3 = 5'd2; W_vin = 32'd7;
    exp_q.push_back(32'd12);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e) begin errors++; $display("FAIL fwd_m_w: got %0d want %0d", M_alu, e); end
    checks++; if (M_v2 !== 32'd7) begin errors++; $display("FAIL fwd_store_data: got %0d want 7", M_v2); end
    checks++; if (M_vin !== e) begin errors++; $display("FAIL fwd_vin: got %0d want %0d", M_vin, e); end
    // previous result now sits in M with a3=3; M and W both name rs: M must win
    drive(bit_of(ADDU), 4'd0, 32'h0, 32'd1, 32'h0, 32'h3008);
    E_a1 = 5'd3; W_grf_en = 1'b1; W_a3 = 5'd3; W_vin = 32'd100;
    exp_q.push_back(32'd13);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e) begin errors++; $display("FAIL fwd_priority: got %0d want %0d", M_alu, e); end
    drive(bit_of(ORI), 4'd0, 32'h0, 32'h0, 32'h5, 32'h300c);
    E_a3 = 5'd0; E_grf_en = 1'b1;
    step();
    drive(bit_of(ADDU), 4'd0, 32'd50, 32'd4, 32'h0, 32'h3010);
    E_a1 = 5'd1; E_a2 = 5'd0; W_grf_en = 1'b1; W_a3 = 5'd1; W_vin = 32'd9;
    exp_q.push_back(32'd13);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e) begin errors++; $display("FAIL fwd_zero_reg: got %0d want %0d", M_alu, e); end
  endtask

  task automatic test_alu();
    int ops[9] = '{ADDU, SUBU, ADD, SUB, AND_, OR_, XOR_, NOR_, -1};
    logic [31:0] a, b;
    for (int i = 0; i < 9; i++) begin
      a = $urandom; b = $urandom;
      drive(ops[i] < 0 ? 28'd0 : bit_of(ops[i]), 4'd0, a, b, 32'hDEAD_BEEF, 32'h3100);
      exp_q.push_back(r_model(ops[i], a, b));
      step();
      e = exp_q.pop_front();
      checks++; if (M_alu !== e) begin errors++; $display("FAIL alu_op%0d: got %h want %h", ops[i], M_alu, e); end
    end
  endtask

  task automatic test_imm_jal();
    drive(bit_of(LUI), 4'd0, 32'hFFFF, 32'h0, 32'h1234_0000, 32'h3000);
    exp_q.push_back(32'h1234_0000);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e) begin errors++; $display("FAIL lui: got %h want %h", M_alu, e); end
    drive(bit_of(JAL), 4'd0, 32'h0, 32'h0, 32'h0, 32'h3010);
    exp_q.push_back(32'h3018);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e) begin errors++; $display("FAIL jal: got %h want %h", M_alu, e); end
    drive(bit_of(ORI), 4'd0, 32'hF0, 32'h0F00, 32'h0F, 32'h3014);
    exp_q.push_back(32'hFF);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e) begin errors++; $display("FAIL ori: got %h want %h", M_alu, e); end
  endtask

  task automatic run_md(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int busy_exp, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    drive(28'd0, op, a, b, 32'h0, 32'h3200);
    step();
    drive(28'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h3204);
    wait_idle(cycles);
    checks++; if (cycles != busy_exp) begin errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", nm, cycles, busy_exp); end
    drive(28'd0, 4'd5, 32'h0, 32'h0, 32'h0, 32'h3208);
    exp_q.push_back(hi_exp);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e) begin errors++; $display("FAIL %s_hi: got %h want %h", nm, M_alu, e); end
    drive(28'd0, 4'd6, 32'h0, 32'h0, 32'h0, 32'h320c);
    exp_q.push_back(lo_exp);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e) begin errors++; $display("FAIL %s_lo: got %h want %h", nm, M_alu, e); end
  endtask

  task automatic test_muldiv();
    run_md("mult",  4'd1, 32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA);
    run_md("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu0", 4'd4, 32'd7,         32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu",  4'd4, 32'd100,       32'd7, 10, 32'd2,         32'd14);
  endtask

  task automatic test_ignored_ops();
    drive(28'd0, 4'd7, 32'hAA, 32'h0, 32'h0, 32'h3300);
    step();
    drive(28'd0, 4'd1, 32'd2, 32'd3, 32'h0, 32'h3304);
    step();
    drive(28'd0, 4'd5, 32'h0, 32'h0, 32'h0, 32'h3308);
    exp_q.push_back(32'hAA);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e || md_busy !== 1'b1) begin errors++; $display("FAIL stale_mfhi: got %h busy=%b want %h busy=1", M_alu, md_busy, e); end
    drive(28'd0, 4'd8, 32'h55, 32'h0, 32'h0, 32'h330c);
    step();
    drive(28'd0, 4'd3, 32'd9, 32'd2, 32'h0, 32'h3310);
    step();
    drive(28'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h3314);
    wait_idle(cycles);
    checks++; if (cycles != 2) begin errors++; $display("FAIL ignored_restart: got %0d remaining busy cycles want 2", cycles); end
    drive(28'd0, 4'd5, 32'h0, 32'h0, 32'h0, 32'h3318);
    exp_q.push_back(32'h0);
    step();
    drive(28'd0, 4'd6, 32'h0, 32'h0, 32'h0, 32'h331c);
    exp_q.push_back(32'd6);
    e = exp_q.pop_front();
    checks++; if (M_alu !== e) begin errors++; $display("FAIL ignored_hi: got %h want %h", M_alu, e); end
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e) begin errors++; $display("FAIL ignored_lo: got %h want %h", M_alu, e); end
  endtask

  task automatic test_reset_mid_div();
    drive(28'd0, 4'd7, 32'h1234, 32'h0, 32'h0, 32'h3400);
    step();
    drive(28'd0, 4'd3, 32'd100, 32'd7, 32'h0, 32'h3404);
    step();
    drive(28'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h3408);
    step(); step(); step();
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", md_busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (md_busy !== 1'b0 || M_pc !== 32'h3000) begin errors++; $display("FAIL rst_async: got busy=%b pc=%h want busy=0 pc=3000", md_busy, M_pc); end
    #3 reset = 1'b1;
    drive(28'd0, 4'd5, 32'h0, 32'h0, 32'h0, 32'h4000);
    exp_q.push_back(32'h0);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e || M_pc !== 32'h4000) begin errors++; $display("FAIL rst_hi: got hi=%h pc=%h want hi=%h pc=4000", M_alu, M_pc, e); end
    drive(28'd0, 4'd6, 32'h0, 32'h0, 32'h0, 32'h4004);
    exp_q.push_back(32'h0);
    step();
    e = exp_q.pop_front();
    checks++; if (M_alu !== e || md_busy !== 1'b0) begin errors++; $display("FAIL rst_lo: got lo=%h busy=%b want lo=%h busy=0", M_alu, md_busy, e); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_alu();
    test_imm_jal();
    test_muldiv();
    test_ignored_ops();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
